// File: rtl/handshake_monitor_pkg.sv
// ---------------------------------------------------------------------------
// handshake_monitor_pkg
// Shared types for the ready/valid protocol monitor:
//   ch_state_e - per-channel FSM state (IDLE, PENDING)
//   err_idx_e  - bit positions of the sticky error vector inside a channel
// ---------------------------------------------------------------------------
package handshake_monitor_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } ch_state_e;

  typedef enum int unsigned {
    ERR_DROP    = 0,
    ERR_DATA    = 1,
    ERR_TIMEOUT = 2
  } err_idx_e;

  localparam int N_ERR = 3;

endpackage

// File: rtl/handshake_monitor_if.sv
// ---------------------------------------------------------------------------
// handshake_monitor_if
// Bundle of N ready/valid channels.
//   ch_valid [N_CHANNELS]            per-channel valid
//   ch_ready [N_CHANNELS]            per-channel ready
//   ch_data  [N_CHANNELS*DATA_WIDTH] payloads, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
// Modports: master (producer), slave (consumer), monitor (passive observer).
// ---------------------------------------------------------------------------
interface handshake_monitor_if #(
  parameter int N_CHANNELS = 4,
  parameter int DATA_WIDTH = 8
);

  logic [N_CHANNELS-1:0]            ch_valid;
  logic [N_CHANNELS-1:0]            ch_ready;
  logic [N_CHANNELS*DATA_WIDTH-1:0] ch_data;

  modport master  (output ch_valid, output ch_data, input  ch_ready);
  modport slave   (input  ch_valid, input  ch_data, output ch_ready);
  modport monitor (input  ch_valid, input  ch_ready, input ch_data);

endinterface

// File: rtl/handshake_channel_monitor.sv
// ---------------------------------------------------------------------------
// handshake_channel_monitor
// Observes one ready/valid channel: counts transfers, tracks the current
// stall length and latches sticky drop / data-change / timeout flags.
// Optional concurrent checkers when HANDSHAKE_MONITOR_ASSERT_EN is defined.
// Ports:
//   CLK, RESETN    clock, synchronous active-low reset
//   clear          synchronous clear (same effect as reset)
//   valid, ready   channel handshake
//   data           channel payload
//   xfer_count     saturating completed-transfer count
//   stall_cycles   saturating current stall length
//   err            sticky flags, indexed by err_idx_e
// ---------------------------------------------------------------------------
module handshake_channel_monitor
  import handshake_monitor_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
`ifdef HANDSHAKE_MONITOR_ASSERT_EN
  , parameter int CH_INDEX     = 0
`endif
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  clear,
  input  logic                  valid,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [CNT_WIDTH-1:0]  xfer_count,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic [N_ERR-1:0]      err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ONE         = CNT_WIDTH'(1);

  ch_state_e             state;
  logic [DATA_WIDTH-1:0] captured;
  logic [CNT_WIDTH-1:0]  xfer_inc;
  logic [CNT_WIDTH-1:0]  stall_inc;

  // Saturating successors: counters stick at all-ones instead of wrapping.
  assign xfer_inc  = (xfer_count   == CNT_MAX) ? CNT_MAX : xfer_count + ONE;
  assign stall_inc = (stall_cycles == CNT_MAX) ? CNT_MAX : stall_cycles + ONE;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK) begin
    if (!RESETN || clear) begin
      state        <= IDLE;
      // NOTE: the captured payload is a plain register, not a memory, so it is
      // reset too; this keeps post-reset comparisons free of X.
      captured     <= '0;
      xfer_count   <= '0;
      stall_cycles <= '0;
      err          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid && ready) begin
            xfer_count <= xfer_inc;
          end else if (valid) begin
            captured     <= data;
            stall_cycles <= ONE;
            state        <= PENDING;
            // A one-cycle timeout budget is already exhausted by the first stall.
            if (TIMEOUT_VAL == ONE) err[ERR_TIMEOUT] <= 1'b1;
          end
        end
        PENDING: begin
          if (!valid) begin
            err[ERR_DROP] <= 1'b1;
            stall_cycles  <= '0;
            state         <= IDLE;
          end else begin
            // Re-capture so a single change is reported once, not every cycle.
            if (data != captured) begin
              err[ERR_DATA] <= 1'b1;
              captured      <= data;
            end
            if (ready) begin
              xfer_count   <= xfer_inc;
              stall_cycles <= '0;
              state        <= IDLE;
            end else begin
              stall_cycles <= stall_inc;
              if (stall_inc == TIMEOUT_VAL) err[ERR_TIMEOUT] <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HANDSHAKE_MONITOR_ASSERT_EN
  a_valid_hold: assert property (@(posedge CLK) disable iff (!RESETN)
    (valid && !ready) |=> valid)
    else $error("channel %0d: valid dropped while stalled, data=0x%0h", CH_INDEX, $sampled(data));

  a_data_stable: assert property (@(posedge CLK) disable iff (!RESETN)
    (valid && !ready) |=> $stable(data))
    else $error("channel %0d: payload changed while stalled, data=0x%0h", CH_INDEX, $sampled(data));

  a_stall_bound: assert property (@(posedge CLK) disable iff (!RESETN)
    not ((valid && !ready) [*TIMEOUT_CYCLES]))
    else $error("channel %0d: stall reached %0d cycles, data=0x%0h", CH_INDEX, TIMEOUT_CYCLES, $sampled(data));
`else
  // Checkers compiled out; the sticky flags are the only reporting path.
`endif

endmodule

// File: rtl/handshake_monitor.sv
// ---------------------------------------------------------------------------
// handshake_monitor
// Passive monitor for N_CHANNELS independent ready/valid channels. Drives no
// DUT signal. Optional SVA enabled by defining HANDSHAKE_MONITOR_ASSERT_EN.
// Ports:
//   CLK, RESETN   clock, synchronous active-low reset
//   clear         synchronous clear of counters, flags and FSMs
//   bus           monitored channels (handshake_monitor_if.monitor)
//   xfer_count    per-channel saturating transfer counts, CNT_WIDTH each
//   stall_cycles  per-channel current stall length, CNT_WIDTH each
//   err_drop      sticky: valid withdrawn before ready
//   err_data      sticky: payload changed while stalled
//   err_timeout   sticky: stall reached TIMEOUT_CYCLES
//   any_err       registered OR of all sticky flags (one cycle behind them)
// ---------------------------------------------------------------------------
module handshake_monitor
  import handshake_monitor_pkg::*;
#(
  parameter int N_CHANNELS     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           CLK,
  input  logic                           RESETN,
  input  logic                           clear,
  handshake_monitor_if.monitor           bus,
  output logic [N_CHANNELS*CNT_WIDTH-1:0] xfer_count,
  output logic [N_CHANNELS*CNT_WIDTH-1:0] stall_cycles,
  output logic [N_CHANNELS-1:0]          err_drop,
  output logic [N_CHANNELS-1:0]          err_data,
  output logic [N_CHANNELS-1:0]          err_timeout,
  output logic                           any_err
);

  for (genvar i = 0; i < N_CHANNELS; i++) begin : gen_ch
    logic [N_ERR-1:0] err;

    handshake_channel_monitor #(
      .DATA_WIDTH     (DATA_WIDTH),
      .CNT_WIDTH      (CNT_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`ifdef HANDSHAKE_MONITOR_ASSERT_EN
      , .CH_INDEX     (i)
`endif
    ) u_ch (
      .CLK          (CLK),
      .RESETN       (RESETN),
      .clear        (clear),
      .valid        (bus.ch_valid[i]),
      .ready        (bus.ch_ready[i]),
      .data         (bus.ch_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .xfer_count   (xfer_count[i*CNT_WIDTH +: CNT_WIDTH]),
      .stall_cycles (stall_cycles[i*CNT_WIDTH +: CNT_WIDTH]),
      .err          (err)
    );

    assign err_drop[i]    = err[ERR_DROP];
    assign err_data[i]    = err[ERR_DATA];
    assign err_timeout[i] = err[ERR_TIMEOUT];
  end

  // Registered summary of the already-registered flags, hence one cycle later.
  always_ff @(posedge CLK) begin
    if (!RESETN || clear) any_err <= 1'b0;
    else                  any_err <= |{err_drop, err_data, err_timeout};
  end

endmodule

// File: tb/tb_handshake_monitor.sv
// ---------------------------------------------------------------------------
// tb_handshake_monitor
// Two monitor instances observe the same channels: A with default counter
// width/timeout, B with CNT_WIDTH=4, TIMEOUT_CYCLES=4 to reach saturation and
// timeout quickly. Directed steps with constant expectations, then random
// traffic, all compared every cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_handshake_monitor;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int CW_A = 16;
  localparam int T_A  = 64;
  localparam int CW_B = 4;
  localparam int T_B  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic clr;

  handshake_monitor_if #(.N_CHANNELS(N), .DATA_WIDTH(DW)) hs_if ();

  logic [N*CW_A-1:0] xfer_a, stall_a;
  logic [N*CW_B-1:0] xfer_b, stall_b;
  logic [N-1:0]      drop_a, data_a, to_a, drop_b, data_b, to_b;
  logic              any_a, any_b;

  handshake_monitor #(.N_CHANNELS(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW_A), .TIMEOUT_CYCLES(T_A)) dut_a (
    .CLK(clk), .RESETN(rstn), .clear(clr), .bus(hs_if),
    .xfer_count(xfer_a), .stall_cycles(stall_a),
    .err_drop(drop_a), .err_data(data_a), .err_timeout(to_a), .any_err(any_a));

  handshake_monitor #(.N_CHANNELS(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW_B), .TIMEOUT_CYCLES(T_B)) dut_b (
    .CLK(clk), .RESETN(rstn), .clear(clr), .bus(hs_if),
    .xfer_count(xfer_b), .stall_cycles(stall_b),
    .err_drop(drop_b), .err_data(data_b), .err_timeout(to_b), .any_err(any_b));

  int checks   = 0;
  int failures = 0;

  // Reference model, index [config][channel]; config 0 = A, 1 = B.
  int t_cfg[2]   = '{T_A, T_B};
  int max_cfg[2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
  bit m_waiting[2][N];   // an offer is outstanding (valid seen without ready)
  int m_offer[2][N];     // payload of the outstanding offer
  int m_stall[2][N];
  int m_xfer[2][N];
  bit m_drop[2][N], m_dchg[2][N], m_to[2][N];
  bit m_any[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  function automatic logic [31:0] o_xfer(input int c, input int ch);
    if (c == 0) return 32'(xfer_a[ch*CW_A +: CW_A]);
    return 32'(xfer_b[ch*CW_B +: CW_B]);
  endfunction

  function automatic logic [31:0] o_stall(input int c, input int ch);
    if (c == 0) return 32'(stall_a[ch*CW_A +: CW_A]);
    return 32'(stall_b[ch*CW_B +: CW_B]);
  endfunction

  function automatic logic [31:0] o_flag(input int c, input int ch, input int kind);
    logic [N-1:0] v;
    case (kind)
      0:       v = (c == 0) ? drop_a : drop_b;
      1:       v = (c == 0) ? data_a : data_b;
      default: v = (c == 0) ? to_a   : to_b;
    endcase
    return 32'(v[ch]);
  endfunction

  function automatic logic [31:0] o_any(input int c);
    return (c == 0) ? 32'(any_a) : 32'(any_b);
  endfunction

  // Apply the protocol rules for one sampled edge.
  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      bit prev_any = 1'b0;
      for (int ch = 0; ch < N; ch++) prev_any |= m_drop[c][ch] | m_dchg[c][ch] | m_to[c][ch];
      m_any[c] = (rstn && !clr) ? prev_any : 1'b0;
      for (int ch = 0; ch < N; ch++) begin
        bit v = hs_if.ch_valid[ch];
        bit r = hs_if.ch_ready[ch];
        int d = int'(hs_if.ch_data[ch*DW +: DW]);
        if (!rstn || clr) begin
          m_waiting[c][ch] = 0; m_offer[c][ch] = 0; m_stall[c][ch] = 0; m_xfer[c][ch] = 0;
          m_drop[c][ch] = 0; m_dchg[c][ch] = 0; m_to[c][ch] = 0;
        end else if (m_waiting[c][ch] && !v) begin
          m_drop[c][ch] = 1; m_stall[c][ch] = 0; m_waiting[c][ch] = 0;
        end else if (v) begin
          if (m_waiting[c][ch] && d != m_offer[c][ch]) m_dchg[c][ch] = 1;
          m_offer[c][ch] = d;
          if (r) begin
            if (m_xfer[c][ch] < max_cfg[c]) m_xfer[c][ch]++;
            m_stall[c][ch] = 0; m_waiting[c][ch] = 0;
          end else begin
            if (m_stall[c][ch] < max_cfg[c]) m_stall[c][ch]++;
            if (m_stall[c][ch] == t_cfg[c]) m_to[c][ch] = 1;
            m_waiting[c][ch] = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 2; c++) begin
      check($sformatf("any_err c%0d", c), o_any(c), 32'(m_any[c]));
      for (int ch = 0; ch < N; ch++) begin
        check($sformatf("xfer_count c%0d ch%0d", c, ch),   o_xfer(c, ch),    32'(m_xfer[c][ch]));
        check($sformatf("stall_cycles c%0d ch%0d", c, ch), o_stall(c, ch),   32'(m_stall[c][ch]));
        check($sformatf("err_drop c%0d ch%0d", c, ch),     o_flag(c, ch, 0), 32'(m_drop[c][ch]));
        check($sformatf("err_data c%0d ch%0d", c, ch),     o_flag(c, ch, 1), 32'(m_dchg[c][ch]));
        check($sformatf("err_timeout c%0d ch%0d", c, ch),  o_flag(c, ch, 2), 32'(m_to[c][ch]));
      end
    end
  endtask

  // One clock edge: model follows the sampled inputs, outputs checked 1 ns later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic set_ch(input int ch, input bit v, input bit r, input logic [DW-1:0] d);
    hs_if.ch_valid[ch]        = v;
    hs_if.ch_ready[ch]        = r;
    hs_if.ch_data[ch*DW +: DW] = d;
  endtask

  initial begin
    logic [DW-1:0] rnd_data [N];
    rstn = 1'b0;
    clr  = 1'b0;
    hs_if.ch_valid = '0;
    hs_if.ch_ready = '0;
    hs_if.ch_data  = '0;

    // Reset state
    step(); step();
    check("reset xfer_a", 32'(xfer_a), 32'd0);
    check("reset flags_a", 32'({drop_a, data_a, to_a, any_a}), 32'd0);
    rstn = 1'b1;

    // Ten back-to-back transfers on channel 0
    for (int i = 0; i < 10; i++) begin
      set_ch(0, 1, 1, DW'(i));
      step();
    end
    set_ch(0, 0, 0, '0);
    step();
    check("ch0 ten xfers A", o_xfer(0, 0), 32'd10);
    check("ch0 ten xfers B", o_xfer(1, 0), 32'd10);
    check("ch0 stall idle", o_stall(0, 0), 32'd0);
    check("no flags after xfers", 32'({drop_a, data_a, to_a, any_a}), 32'd0);

    // Channel 1: three stall cycles at 0xA5, then accepted
    set_ch(1, 1, 0, 8'hA5);
    repeat (3) step();
    check("ch1 stall peak", o_stall(0, 1), 32'd3);
    set_ch(1, 1, 1, 8'hA5);
    step();
    check("ch1 stall cleared", o_stall(0, 1), 32'd0);
    check("ch1 one xfer", o_xfer(0, 1), 32'd1);
    set_ch(1, 0, 0, '0);
    step();
    check("ch1 no flags", 32'({drop_a, data_a, to_a, any_a}), 32'd0);

    // Channel 2: valid withdrawn while stalled
    set_ch(2, 1, 0, 8'h3C);
    step();
    set_ch(2, 0, 0, '0);
    step();
    check("ch2 err_drop", 32'(drop_a[2]), 32'd1);
    check("any_err lags flag", 32'(any_a), 32'd0);
    step();
    check("any_err after drop", 32'(any_a), 32'd1);
    check("other channels no drop", 32'({drop_a[3], drop_a[1:0]}), 32'd0);

    // Channel 3: payload changes while stalled
    set_ch(3, 1, 0, 8'h11);
    step();
    set_ch(3, 1, 0, 8'h22);
    step();
    check("ch3 err_data", 32'(data_a[3]), 32'd1);
    set_ch(3, 1, 1, 8'h22);
    step();
    check("ch3 xfer after change", o_xfer(0, 3), 32'd1);
    set_ch(3, 0, 0, '0);
    step();

    // Channel 0: six-cycle stall, B times out at the fourth edge
    set_ch(0, 1, 0, 8'h5A);
    repeat (3) step();
    check("B timeout not yet", 32'(to_b[0]), 32'd0);
    step();
    check("B timeout at T", 32'(to_b[0]), 32'd1);
    check("B stall at T", o_stall(1, 0), 32'd4);
    step(); step();
    check("B stall keeps counting", o_stall(1, 0), 32'd6);
    check("A no timeout", 32'(to_a[0]), 32'd0);
    set_ch(0, 1, 1, 8'h5A);
    step();

    // Twenty more transfers: B saturates at 15
    repeat (20) step();
    check("B xfer saturated", o_xfer(1, 0), 32'd15);
    check("A xfer count", o_xfer(0, 0), 32'd31);

    // Clear together with a transfer
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clear drops xfer A", o_xfer(0, 0), 32'd0);
    check("clear drops xfer B", o_xfer(1, 0), 32'd0);
    check("clear drops flags", 32'({drop_b, data_b, to_b, any_b, drop_a, data_a, to_a, any_a}), 32'd0);
    set_ch(0, 0, 0, '0);
    step();

    // Long stall on channel 1: A times out at 64, B's stall counter saturates
    set_ch(1, 1, 0, 8'h77);
    repeat (63) step();
    check("A timeout not yet", 32'(to_a[1]), 32'd0);
    step();
    check("A timeout at 64", 32'(to_a[1]), 32'd1);
    check("A stall at 64", o_stall(0, 1), 32'd64);
    repeat (6) step();
    check("A stall 70", o_stall(0, 1), 32'd70);
    check("B stall saturated", o_stall(1, 1), 32'd15);

    // Reset mid-stall discards the stall without a flag
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check("reset mid-stall", o_stall(0, 1), 32'd0);
    check("reset clears timeout", 32'(to_a), 32'd0);
    set_ch(1, 0, 0, '0);
    step();

    // Random traffic against the model
    for (int ch = 0; ch < N; ch++) rnd_data[ch] = '0;
    for (int n = 0; n < 600; n++) begin
      for (int ch = 0; ch < N; ch++) begin
        if ($urandom_range(3) == 0) rnd_data[ch] = DW'($urandom_range(3));
        set_ch(ch, $urandom_range(4) != 0, $urandom_range(2) == 0, rnd_data[ch]);
      end
      clr  = ($urandom_range(80) == 0);
      rstn = ($urandom_range(150) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/handshake_monitor.md
# handshake_monitor

Parametrised, passive ready/valid protocol monitor for N independent channels, bound into a DUT alongside its RTL. Per channel, it counts completed transfers, measures stall duration, and latches sticky violation flags for valid-drop, payload instability and stall timeout. It drives no DUT signal. Its outputs exist for bench observation and, optionally, for concurrent assertions.

## Interface
- N_CHANNELS, 4: number of monitored handshake channels (≥1)
- DATA_WIDTH, 8: payload width per channel (≥1)
- CNT_WIDTH, 16: width of each transfer counter and stall counter
- TIMEOUT_CYCLES, 64: consecutive stall cycles that raise a timeout (1 .. 2^CNT_WIDTH-1)

Ports:
- CLK  in  1  sole clock, rising edge
- RESETN  in  1  synchronous, active-low reset
- clear  in  1  synchronous clear of counters and sticky flags
- ch_valid  in  N_CHANNELS  per-channel valid
- ch_ready  in  N_CHANNELS  per-channel ready
- ch_data  in  N_CHANNELS*DATA_WIDTH  payloads; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- xfer_count  out  N_CHANNELS*CNT_WIDTH  completed transfers per channel; saturating
- stall_cycles  out  N_CHANNELS*CNT_WIDTH  current consecutive stall length per channel
- err_drop  out  N_CHANNELS  sticky: valid deasserted before ready
- err_data  out  N_CHANNELS  sticky: payload changed while stalled
- err_timeout  out  N_CHANNELS  sticky: stall reached TIMEOUT_CYCLES
- any_err  out  1  OR of all sticky flags, registered

## Operation
- Each channel runs a two-state FSM: IDLE and PENDING.
- IDLE:
  - valid&&ready: transfer. xfer_count increments. Stay IDLE.
  - valid&&!ready: capture data. stall_cycles←1. Go to PENDING.
- PENDING:
  - !valid: set err_drop. stall_cycles←0. Go to IDLE.
  - valid with data ≠ captured: set err_data. Re-capture the new data, so one change flags once.
  - valid&&ready: transfer. xfer_count increments. stall_cycles←0. Go to IDLE.
  - valid&&!ready: stall_cycles increments, saturating.
  - When stall_cycles reaches TIMEOUT_CYCLES: set err_timeout. The flag sets once per stall and stays set.
- The data check and the drop/transfer decision happen in the same cycle. A transfer carrying changed data counts and also flags err_data.
- Counters saturate at all-ones and never wrap.
- Sticky flags clear only on reset or clear.
- Channels are fully independent. There is no cross-channel ordering check.

## Timing
- All outputs are registered. An event sampled at edge k is visible after edge k.
- any_err lags the per-channel flags by one cycle.
- Reset (RESETN low at an edge) sets every output to 0, every FSM to IDLE, and every captured payload to 0.
- Reset mid-stall discards the stall with no flag.
- clear has the same effect as reset on counters, flags and FSMs.
- Priority: reset > clear > normal update. A transfer in the same cycle as clear is not counted.
- Flag latency: err_drop and err_data are high one cycle after the offending sample.
- err_timeout timing: with valid high and ready low at edges 1..T (T = TIMEOUT_CYCLES), err_timeout is high after edge T.

## Configuration
- HANDSHAKE_MONITOR_ASSERT_EN defined:
  - Per channel, emit concurrent SVA on CLK, disabled iff !RESETN.
  - Properties: valid&&!ready |=> valid; valid&&!ready |=> $stable(data); stall bounded by TIMEOUT_CYCLES.
  - Each failure also prints channel index and payload via $error.
- HANDSHAKE_MONITOR_ASSERT_EN undefined:
  - No assertions and no $error.
  - Sticky flags and counters behave identically.

## Structure
- handshake_monitor_pkg holds the FSM state typedef (IDLE, PENDING) and an error-bit index enum (ERR_DROP, ERR_DATA, ERR_TIMEOUT).
- Sub-module handshake_channel_monitor implements one channel: FSM, captured payload, counters, flags, optional SVA.
  - The top instantiates it N_CHANNELS times in a generate loop.
  - The top slices the flat buses and ORs the flags into any_err.

## Test plan
- Reset then 10 back-to-back transfers on channel 0 (valid=ready=1): xfer_count[0]=10, all flags 0, stall_cycles[0]=0.
- Channel 1: valid=1, ready=0 for 3 cycles, data held at 0xA5, then ready=1: stall_cycles peaks at 3, xfer_count[1]=1, no flags.
- Channel 2: valid=1, ready=0, then valid=0 next cycle: err_drop[2]=1 one cycle later, any_err=1 the cycle after. Other channels unaffected.
- Channel 3: valid=1, ready=0, data 0x11 changes to 0x22 while stalled: err_data[3]=1. With HANDSHAKE_MONITOR_ASSERT_EN defined, exactly one $stable failure is reported.
- TIMEOUT_CYCLES=4, channel 0 stalled for 6 cycles: err_timeout[0] is high after the 4th stall edge, and stall_cycles keeps counting to 6.
- CNT_WIDTH=4, 20 transfers: xfer_count saturates at 15. Asserting clear together with a transfer leaves xfer_count=0 and clears all flags.
